// File: rtl/hazard_controller_if.sv
// hazard_controller_if: ID-stage instruction/memory status in, stall, bubble, flush and freeze controls out.
interface hazard_controller_if #(
  parameter int INST_WIDTH = 32,
  parameter int STALL_CNT_W = 16
);
  logic id_valid;
  logic [INST_WIDTH-1:0] id_inst;
  logic id_redirect;
  logic mem_busy;
  logic stall_if;
  logic stall_id;
  logic bubble_ex;
  logic flush_id;
  logic freeze;
  logic [1:0] state;
  logic [STALL_CNT_W-1:0] stall_count;
  modport master(
    output id_valid, id_inst, id_redirect, mem_busy,
    input stall_if, stall_id, bubble_ex, flush_id, freeze, state, stall_count
  );
  modport slave(
    input id_valid, id_inst, id_redirect, mem_busy,
    output stall_if, stall_id, bubble_ex, flush_id, freeze, state, stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: load-use stalls, SYSTEM serialisation and memory freeze for the decode stage.
module hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int INST_WIDTH = 32,
  parameter int STALL_CNT_W = 16
) (
  input logic clk,
  input logic rst_n,
  hazard_controller_if.slave bus
);
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_OP = 7'b0110011,
                         OP_SYSTEM = 7'b1110011;
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, SERIAL = 2'd2} state_t;
  typedef struct packed {
    logic valid;
    logic [REG_ADDR_W-1:0] rd;
    logic wr;
    logic load;
    logic sys;
  } slot_t;
  state_t state, state_nx;
  slot_t ex, mem, wb, ex_nx;
  logic [STALL_CNT_W-1:0] cnt;
  logic [6:0] opc;
  logic [2:0] f3;
  logic [REG_ADDR_W-1:0] rd, rs1, rs2;
  logic uses_rs1, uses_rs2, writes_rd, is_load, is_sys, sys_req, pipe_busy, lu, stall, issue;
  assign opc = bus.id_inst[6:0];
  assign rd = bus.id_inst[7 +: REG_ADDR_W];
  assign f3 = bus.id_inst[14:12];
  assign rs1 = bus.id_inst[15 +: REG_ADDR_W];
  // rs2 sits directly below the 7-bit funct7 field at the top of the word
  assign rs2 = bus.id_inst[INST_WIDTH-8 -: REG_ADDR_W];
  assign is_load = opc == OP_LOAD;
  assign is_sys = opc == OP_SYSTEM;
  assign uses_rs1 = (opc inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP})
                    | (is_sys & f3 != 3'b000 & !f3[2]);
  assign uses_rs2 = opc inside {OP_BRANCH, OP_STORE, OP_OP};
  assign writes_rd = (opc inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP})
                     | (is_sys & f3 != 3'b000);
  assign pipe_busy = ex.valid | mem.valid | wb.valid;
  assign sys_req = bus.id_valid & is_sys;
  assign lu = ex.valid & ex.load & ex.wr & ((uses_rs1 & rs1 == ex.rd) | (uses_rs2 & rs2 == ex.rd));
  assign stall = bus.mem_busy | lu | (state == DRAIN & pipe_busy)
                 | (state == RUN & sys_req & pipe_busy) | state == SERIAL;
  assign issue = bus.id_valid & !stall & !bus.mem_busy;
  assign ex_nx = issue ? {1'b1, rd, writes_rd & rd != '0, is_load, is_sys} : '0;
  assign bus.stall_id = stall;
  assign bus.stall_if = stall;
  assign bus.freeze = bus.mem_busy;
  assign bus.bubble_ex = stall & !bus.mem_busy;
  assign bus.flush_id = issue & bus.id_redirect;
  assign bus.state = state;
  assign bus.stall_count = cnt;
  always_comb begin
    state_nx = state;
    if (!bus.mem_busy)
      case (state)
        RUN: state_nx = (sys_req & pipe_busy) ? DRAIN : (sys_req & issue) ? SERIAL : RUN;
        DRAIN: state_nx = pipe_busy ? DRAIN : issue ? SERIAL : RUN;
        SERIAL: state_nx = (wb.valid & wb.sys) ? RUN : SERIAL;
        default: state_nx = RUN;
      endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RUN;
      ex <= '0;
      mem <= '0;
      wb <= '0;
      cnt <= '0;
    end else begin
      if (!bus.mem_busy) begin
        state <= state_nx;
        ex <= ex_nx;
        mem <= ex;
        wb <= mem;
      end
      if (stall & ~&cnt) cnt <= cnt + 1'b1;
    end
  end
endmodule
